execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls for the instruction in E.
REQ-005 ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-006 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands and PC values from the ID/EX register.
REQ-007 RD_E  in  5  destination register of the instruction in E.
REQ-008 ForwardAE, ForwardBE  in  2 each  operand selects from the forwarding unit: 00 register file, 01 W result, 10 M ALU result.
REQ-009 ResultW  in  XLEN  write-back result.
REQ-010 StallM  in  1  hold the E/M register.
REQ-011 FlushM  in  1  load a bubble into the E/M register.
REQ-012 PCSrcE  out  1  branch taken.
REQ-013 PCTargetE  out  XLEN  branch target.
REQ-014 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls.
REQ-015 RD_M  out  5  registered destination register.
REQ-016 ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  registered data; ALUResultM is also the forwarding source for select 10.

Function
REQ-017 SrcAE SHALL be RD1_E, ResultW or ALUResultM for ForwardAE 00, 01 or 10 respectively; select 11 SHALL behave as 00.
REQ-018 The forwarded B operand SHALL use the same selection on ForwardBE with RD2_E; select 11 SHALL behave as 00.
REQ-019 SrcBE SHALL be Imm_Ext_E when ALUSrcE=1, otherwise the forwarded B operand.
REQ-020 The ALU SHALL compute add/sub modulo 2^XLEN, bitwise and/or, and signed slt (result 1 or 0); undefined ALUControlE codes SHALL yield 0.
REQ-021 ZeroE SHALL be 1 iff the ALU result equals 0.
REQ-022 PCSrcE SHALL equal BranchE & ZeroE, combinationally in the same cycle.
REQ-023 PCTargetE SHALL equal PCE + Imm_Ext_E modulo 2^XLEN, combinationally.
REQ-024 On each clk edge with rst=0, FlushM=0 and StallM=0, the E/M register SHALL capture the following, giving 1-cycle latency E to M:
- RegWriteE, MemWriteE, ResultSrcE and RD_E
- the ALU result
- the forwarded B operand (never the immediate), into WriteDataM
- PCPlus4E
REQ-025 When StallM=1 and FlushM=0, all E/M outputs SHALL hold their values.
REQ-026 When FlushM=1 (with or without StallM), RegWriteM, MemWriteM and ResultSrcM SHALL become 0 and RD_M SHALL become 0; the data fields SHALL become 0.
REQ-027 Priority SHALL be rst > FlushM > StallM > capture.
REQ-028 A forward select of 10 SHALL use the pre-edge ALUResultM, so back-to-back dependent instructions chain correctly.

Reset
REQ-029 While rst=1 at a clk edge, every registered output (RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M) SHALL become 0.
REQ-030 Reset SHALL override a simultaneous FlushM or StallM.
REQ-031 During reset, PCSrcE and PCTargetE SHALL remain combinational functions of their inputs; upstream keeps BranchE=0 during reset.
REQ-032 On the first edge after rst deasserts, the block SHALL capture normally (no extra bubble cycle).

Structure
REQ-033 The shared package riscv_pkg SHALL hold XLEN, the ALUControl encodings and the forward-select encodings (FWD_REG=00, FWD_W=01, FWD_M=10).
REQ-034 The ALU SHALL be a separate sub-module named alu (inputs A, B, ALUControl; outputs Result, Zero).
REQ-035 The forwarding muxes, target adder and E/M register SHALL reside in execute_stage.

Verification
REQ-036 Reset: hold rst=1 for 2 cycles with random inputs -> all M outputs 0.
REQ-037 Forward chain: RD1_E=5, ForwardAE=10 with ALUResultM=7, Imm=3, ALUSrcE=1, add -> ALUResultM=10 next cycle.
REQ-038 W forwarding: ForwardBE=01, ResultW=0xFFFF_FFFF, RD2_E=9, ALUSrcE=0, MemWriteE=1 -> WriteDataM=0xFFFF_FFFF and MemWriteM=1.
REQ-039 Branch: sub with RD1_E=RD2_E=4, BranchE=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120 in the same cycle; with RD2_E=5 -> PCSrcE=0.
REQ-040 Stall/flush: StallM=1 for 2 cycles -> outputs hold; FlushM=1 together with StallM=1 -> RegWriteM=0 and RD_M=0.
REQ-041 slt: SrcA=0x8000_0000, SrcB=1 -> ALUResultM=1; undefined code 111 -> 0; add 0xFFFF_FFFF+1 -> 0, wrapping.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the execute stage.
//   XLEN            - datapath width
//   ALU_*           - ALUControl encodings (add, sub, and, or, slt)
//   FWD_*           - forwarding-unit operand select encodings
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/alu.sv
// alu: purely combinational integer ALU.
//   A, B        in  WIDTH  operands
//   ALUControl  in  3      operation select (see riscv_pkg ALU_*)
//   Result      out WIDTH  operation result; unknown codes give 0
//   Zero        out 1      high when Result is all zeros
module alu
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::XLEN
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  logic lt_signed;

  assign lt_signed = ($signed(A) < $signed(B));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(WIDTH-1){1'b0}}, lt_signed};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of a 5-stage RISC-V pipeline plus the E/M register.
//   clk, rst                       clock, synchronous active-high reset
//   *E controls, RD_E              decoded controls / destination for the E instruction
//   RD1_E, RD2_E, Imm_Ext_E        operands and immediate
//   PCE, PCPlus4E                  PC values of the E instruction
//   ForwardAE, ForwardBE, ResultW  forwarding selects and W-stage result
//   StallM, FlushM                 hold / bubble the E/M register
//   PCSrcE, PCTargetE              combinational branch decision and target
//   *M outputs                     registered E/M state; ALUResultM also feeds forwarding
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a_e;
  logic [XLEN-1:0] fwd_b_e;
  logic [XLEN-1:0] src_b_e;
  logic [XLEN-1:0] alu_result_e;
  logic            zero_e;

  logic            reg_write_q,   reg_write_d;
  logic            mem_write_q,   mem_write_d;
  logic            result_src_q,  result_src_d;
  logic [4:0]      rd_q,          rd_d;
  logic [XLEN-1:0] alu_result_q,  alu_result_d;
  logic [XLEN-1:0] write_data_q,  write_data_d;
  logic [XLEN-1:0] pc_plus4_q,    pc_plus4_d;

  // Forwarding muxes. The M source is the registered value, i.e. the result
  // of the previous instruction, so dependent back-to-back ops chain. The
  // unused select 11 falls back to the register-file value.
  always_comb begin
    src_a_e = RD1_E;
    case (ForwardAE)
      FWD_W:   src_a_e = ResultW;
      FWD_M:   src_a_e = alu_result_q;
      default: src_a_e = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b_e = RD2_E;
    case (ForwardBE)
      FWD_W:   fwd_b_e = ResultW;
      FWD_M:   fwd_b_e = alu_result_q;
      default: fwd_b_e = RD2_E;
    endcase
  end

  assign src_b_e = ALUSrcE ? Imm_Ext_E : fwd_b_e;

  alu #(.WIDTH(XLEN)) u_alu (
    .A          (src_a_e),
    .B          (src_b_e),
    .ALUControl (ALUControlE),
    .Result     (alu_result_e),
    .Zero       (zero_e)
  );

  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + Imm_Ext_E;

  // E/M register next state: flush beats stall beats capture. Reset is
  // applied in the flop process so it overrides everything.
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    if (FlushM) begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 1'b0;
      rd_d         = '0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
    end else if (!StallM) begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RD_E;
      alu_result_d = alu_result_e;
      // Store data is the forwarded register operand, never the immediate.
      write_data_d = fwd_b_e;
      pc_plus4_d   = PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: scoreboard bench for execute_stage. The stimulus process
// drives one instruction per cycle on the falling edge, checks the
// combinational branch outputs, and pushes the expected E/M contents into a
// queue; the monitor pops one entry after every rising edge and compares.
module tb_execute_stage;

  typedef struct {
    logic        rst;
    logic        regw, memw, ress, br, alusrc;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, pc, pc4, resw;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic        stall, flush;
  } stim_t;

  typedef struct {
    logic        regw, memw, ress;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } em_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallM, FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int checks = 0;
  int errors = 0;
  em_t exp_q[$];
  em_t ref_m;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.rst = 0; s.regw = 0; s.memw = 0; s.ress = 0; s.br = 0; s.alusrc = 0;
    s.op = 3'b000; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.pc = 0; s.pc4 = 0;
    s.resw = 0; s.rd = 0; s.fa = 0; s.fb = 0; s.stall = 0; s.flush = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [2:0] ops [6];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b000};
    s = zero_stim();
    s.regw   = 1'($urandom);
    s.memw   = 1'($urandom);
    s.ress   = 1'($urandom);
    s.br     = 1'($urandom);
    s.alusrc = 1'($urandom);
    s.op     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : ops[$urandom_range(0, 5)];
    s.rd1    = $urandom;
    s.rd2    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
    s.imm    = $urandom;
    s.pc     = $urandom;
    s.pc4    = s.pc + 32'd4;
    s.resw   = $urandom;
    s.rd     = 5'($urandom);
    s.fa     = 2'($urandom);
    s.fb     = 2'($urandom);
    s.stall  = ($urandom_range(0, 5) == 0);
    s.flush  = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                       input logic [31:0] w_v, input logic [31:0] m_v);
    if (sel == 2'd1) return w_v;
    if (sel == 2'd2) return m_v;
    return reg_v;
  endfunction

  // Reference behaviour of one E-stage instruction: what the ALU must
  // produce and what the E/M register must hold after the next edge.
  task automatic apply(input stim_t s);
    logic [31:0] a, fb, b, res;
    em_t nx;
    @(negedge clk);
    rst = s.rst; RegWriteE = s.regw; MemWriteE = s.memw; ResultSrcE = s.ress;
    BranchE = s.br; ALUSrcE = s.alusrc; ALUControlE = s.op; RD1_E = s.rd1;
    RD2_E = s.rd2; Imm_Ext_E = s.imm; PCE = s.pc; PCPlus4E = s.pc4;
    ResultW = s.resw; RD_E = s.rd; ForwardAE = s.fa; ForwardBE = s.fb;
    StallM = s.stall; FlushM = s.flush;
    #1;
    a  = pick(s.fa, s.rd1, s.resw, ref_m.alu);
    fb = pick(s.fb, s.rd2, s.resw, ref_m.alu);
    b  = s.alusrc ? s.imm : fb;
    case (s.op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b101:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, s.br && (res == 32'd0)});
    chk("PCTargetE", PCTargetE, s.pc + s.imm);
    if (s.rst || s.flush) begin
      nx.regw = 0; nx.memw = 0; nx.ress = 0; nx.rd = 0;
      nx.alu = 0; nx.wd = 0; nx.pc4 = 0;
    end else if (s.stall) begin
      nx = ref_m;
    end else begin
      nx.regw = s.regw; nx.memw = s.memw; nx.ress = s.ress; nx.rd = s.rd;
      nx.alu = res; nx.wd = fb; nx.pc4 = s.pc4;
    end
    exp_q.push_back(nx);
    ref_m = nx;
  endtask

  // Monitor: the E/M register changes only at the rising edge, so every
  // edge presents one new set of outputs to compare.
  initial begin
    em_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("RegWriteM",  {31'd0, RegWriteM},  {31'd0, e.regw});
        chk("MemWriteM",  {31'd0, MemWriteM},  {31'd0, e.memw});
        chk("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, e.ress});
        chk("RD_M",       {27'd0, RD_M},       {27'd0, e.rd});
        chk("ALUResultM", ALUResultM, e.alu);
        chk("WriteDataM", WriteDataM, e.wd);
        chk("PCPlus4M",   PCPlus4M,   e.pc4);
      end
    end
  end

  initial begin
    stim_t s;
    ref_m = '{regw: 0, memw: 0, ress: 0, rd: 0, alu: 0, wd: 0, pc4: 0};
    rst = 1; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0; RD_E = 0; ForwardAE = 0;
    ForwardBE = 0; StallM = 0; FlushM = 0;

    // Reset for two cycles with random inputs, including flush/stall.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1; s.br = 0;
      apply(s);
    end

    // Forward chain through M: 3+4=7, then 5 (M-forwarded 7 replaces it) +3.
    s = zero_stim(); s.regw = 1; s.rd = 5'd3; s.rd1 = 32'd3; s.imm = 32'd4;
    s.alusrc = 1; s.pc4 = 32'h44;
    apply(s);
    s = zero_stim(); s.regw = 1; s.rd = 5'd4; s.rd1 = 32'd5; s.fa = 2'b10;
    s.imm = 32'd3; s.alusrc = 1; s.pc4 = 32'h48;
    apply(s);

    // W forwarding into store data.
    s = zero_stim(); s.memw = 1; s.fb = 2'b01; s.resw = 32'hFFFF_FFFF;
    s.rd2 = 32'd9; s.rd1 = 32'd1;
    apply(s);

    // Branch taken / not taken.
    s = zero_stim(); s.op = 3'b001; s.rd1 = 32'd4; s.rd2 = 32'd4; s.br = 1;
    s.pc = 32'h100; s.imm = 32'h20;
    apply(s);
    s.rd2 = 32'd5;
    apply(s);

    // slt with a negative A, undefined op, wrapping add.
    s = zero_stim(); s.op = 3'b101; s.rd1 = 32'h8000_0000; s.rd2 = 32'd1;
    apply(s);
    s.op = 3'b111; s.rd1 = 32'h1234; s.rd2 = 32'h1;
    apply(s);
    s = zero_stim(); s.op = 3'b000; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.br = 1;
    apply(s);

    // Capture, stall twice (outputs must hold), then flush with stall.
    s = zero_stim(); s.regw = 1; s.rd = 5'd17; s.rd1 = 32'd10; s.rd2 = 32'd20;
    s.pc4 = 32'h200;
    apply(s);
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.stall = 1; s.flush = 0;
      apply(s);
    end
    s = rand_stim(); s.stall = 1; s.flush = 1;
    apply(s);

    // Reset in the middle, then normal capture right after release.
    s = rand_stim(); s.rst = 1; s.br = 0;
    apply(s);
    s = rand_stim(); s.stall = 0; s.flush = 0;
    apply(s);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      if ($urandom_range(0, 31) == 0) begin
        s.rst = 1; s.br = 0;
      end
      apply(s);
    end

    // Let the monitor drain; anything left over is a missed comparison.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
